// File: rtl/axi_mem_dump_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_dump_reader_if
// Brief    : AXI4 read channels plus the address-tagged output word stream.
// Revision : 1.0
// ============================================================================
interface axi_mem_dump_reader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  ar_valid;
    logic                  ar_ready;

    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic                  r_valid;
    logic                  r_ready;

    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready,
        output out_addr, out_data, out_last, out_valid,
        input  out_ready
    );

    modport slave (
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid,
        input  r_ready,
        input  out_addr, out_data, out_last, out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/axi_mem_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_dump_reader
// Brief    : Walks a word range with 4 KB-safe INCR bursts, streams addr+data.
// Revision : 1.0
// ============================================================================
module axi_mem_dump_reader #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 4,
    parameter int AXI_ID        = 0,
    parameter int MAX_BURST_LEN = 16,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    axi_mem_dump_reader_if.master  bus
);
    localparam int c_BYTES = DATA_WIDTH / 8;
    localparam int c_SIZE  = $clog2(c_BYTES);
    localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ADDR_WIDTH'((1 << c_SIZE) - 1);
    localparam logic [ADDR_WIDTH-1:0] c_STEP       = ADDR_WIDTH'(c_BYTES);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ADDR   = 2'd1;
    localparam logic [1:0] c_DATA   = 2'd2;
    localparam logic [1:0] c_FINISH = 2'd3;

    logic [1:0]             r_state;
    logic [ADDR_WIDTH-1:0]  r_cur_addr;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic [8:0]             r_beat_cnt;
    logic                   r_ar_valid;
    logic [ADDR_WIDTH-1:0]  r_ar_addr;
    logic [7:0]             r_ar_len;
    logic                   r_out_valid;
    logic [ADDR_WIDTH-1:0]  r_out_addr;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic                   r_out_last;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;

    logic                   w_out_free;
    logic                   w_ar_hs;
    logic                   w_r_hs;
    logic                   w_beat_bad;
    logic [ADDR_WIDTH-1:0]  w_start_addr;
    logic [ADDR_WIDTH-1:0]  w_next_addr;
    logic [COUNT_WIDTH-1:0] w_next_rem;

    // Burst size limited by words left, the burst cap and the current 4 KB page.
    function automatic logic [8:0] f_beats(input logic [11:0] page_off,
                                           input logic [COUNT_WIDTH-1:0] rem);
        logic [31:0] v_b;
        logic [31:0] v_page;
        v_page = (32'd4096 - {20'd0, page_off}) >> c_SIZE;
        v_b    = 32'(rem);
        if (v_b > 32'(MAX_BURST_LEN)) v_b = 32'(MAX_BURST_LEN);
        if (v_b > v_page)             v_b = v_page;
        return 9'(v_b);
    endfunction

    assign w_out_free   = !r_out_valid || bus.out_ready;
    assign w_ar_hs      = r_ar_valid && bus.ar_ready;
    assign w_r_hs       = (r_state == c_DATA) && w_out_free && bus.r_valid;
    assign w_start_addr = base_addr & ~c_ALIGN_MASK;
    assign w_next_addr  = r_cur_addr + c_STEP;
    assign w_next_rem   = r_remaining - COUNT_WIDTH'(1);
    assign w_beat_bad   = (bus.r_resp != 2'b00) || (bus.r_id != ID_WIDTH'(AXI_ID)) ||
                          (bus.r_last != (r_beat_cnt == 9'd1));

    assign bus.ar_id     = ID_WIDTH'(AXI_ID);
    assign bus.ar_addr   = r_ar_addr;
    assign bus.ar_len    = r_ar_len;
    assign bus.ar_size   = 3'(c_SIZE);
    assign bus.ar_burst  = 2'b01;
    assign bus.ar_valid  = r_ar_valid;
    assign bus.r_ready   = (r_state == c_DATA) && w_out_free;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_valid = r_out_valid;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_beat_cnt  <= '0;
            r_ar_valid  <= 1'b0;
            r_ar_addr   <= '0;
            r_ar_len    <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_cur_addr  <= w_start_addr;
                        r_remaining <= word_count;
                        r_error     <= 1'b0;
                        r_busy      <= 1'b1;
                        if (word_count == '0) begin
                            r_state <= c_FINISH;
                        end else begin
                            r_state    <= c_ADDR;
                            r_ar_valid <= 1'b1;
                            r_ar_addr  <= w_start_addr;
                            r_ar_len   <= 8'(f_beats(w_start_addr[11:0], word_count) - 9'd1);
                        end
                    end
                end
                c_ADDR: begin
                    if (w_ar_hs) begin
                        r_ar_valid <= 1'b0;
                        r_beat_cnt <= {1'b0, r_ar_len} + 9'd1;
                        r_state    <= c_DATA;
                    end
                end
                c_DATA: begin
                    if (w_r_hs) begin
                        r_out_valid <= 1'b1;
                        r_out_addr  <= r_cur_addr;
                        r_out_data  <= bus.r_data;
                        r_out_last  <= (w_next_rem == '0);
                        r_cur_addr  <= w_next_addr;
                        r_remaining <= w_next_rem;
                        r_beat_cnt  <= r_beat_cnt - 9'd1;
                        if (w_beat_bad) r_error <= 1'b1;
                        // The beat counter, not r_last, closes the burst.
                        if (r_beat_cnt == 9'd1) begin
                            if (w_next_rem != '0) begin
                                r_state    <= c_ADDR;
                                r_ar_valid <= 1'b1;
                                r_ar_addr  <= w_next_addr;
                                r_ar_len   <= 8'(f_beats(w_next_addr[11:0], w_next_rem) - 9'd1);
                            end else begin
                                r_state <= c_FINISH;
                            end
                        end
                    end
                end
                default: begin
                    // Done is held off until the last word has left the output register.
                    if (r_done) begin
                        r_state <= c_IDLE;
                    end else if (w_out_free) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/axi_mem_dump_reader.md
Name: axi_mem_dump_reader

Overview:
- AXI4 read initiator that walks a word-aligned address range on a NoC-attached memory node with INCR bursts.
- Streams every returned word, tagged with its address, on a valid/ready output port.
- Hardware counterpart of the bench-side RAM image loader: used for end-of-run memory dumps and on-chip checksum/debug readout, without hierarchical access.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, AXI data and stream word width (power of 2, >= 8)
ID_WIDTH, 4, AXI ID width
AXI_ID, 0, constant ID driven on ar_id and expected on r_id
MAX_BURST_LEN, 16, maximum beats per burst (1..256)
COUNT_WIDTH, 16, width of word_count

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to begin a dump; sampled only in IDLE
base_addr  in  ADDR_WIDTH  start byte address; low log2(DATA_WIDTH/8) bits ignored (forced 0)
word_count  in  COUNT_WIDTH  number of words to read
busy  out  1  high from the cycle after accepted start until the done pulse
done  out  1  one-cycle pulse at end of dump
error  out  1  sticky; cleared on accepted start
ar_id  out  ID_WIDTH  = AXI_ID
ar_addr  out  ADDR_WIDTH  burst start address
ar_len  out  8  beats-1
ar_size  out  3  log2(DATA_WIDTH/8)
ar_burst  out  2  2'b01 (INCR)
ar_valid  out  1  AR request
ar_ready  in  1  AR accept
r_id  in  ID_WIDTH  read ID
r_data  in  DATA_WIDTH  read data
r_resp  in  2  read response
r_last  in  1  last beat
r_valid  in  1  R valid
r_ready  out  1  R ready
out_addr  out  ADDR_WIDTH  byte address of out_data
out_data  out  DATA_WIDTH  dumped word
out_last  out  1  final word of dump
out_valid  out  1  stream valid
out_ready  in  1  stream ready

Behaviour:
- Reset state: IDLE; busy=0, done=0, error=0, ar_valid=0, r_ready=0, out_valid=0, out_last=0. ar_addr, ar_len, out_addr, out_data = 0.
- Reset mid-operation: abandons the dump immediately. Outstanding beats are not drained; the system resets the NoC together with this block.
- FSM states: IDLE, ADDR, DATA, FINISH.
- IDLE, start=1:
  - latch aligned base_addr into cur_addr and word_count into remaining; clear error.
  - word_count=0: go to FINISH (no AR issued).
  - otherwise: go to ADDR.
- ADDR:
  - ar_valid=1; ar_addr=cur_addr.
  - beats = min(remaining, MAX_BURST_LEN, words remaining to next 4 KB boundary); ar_len = beats-1.
  - Fields are held stable until ar_valid && ar_ready, then go to DATA.
  - beat_cnt = beats.
- DATA:
  - r_ready = !out_valid || out_ready (single output register; no data loss under backpressure).
  - Each R handshake loads out_data=r_data and out_addr=cur_addr, sets out_valid, cur_addr += DATA_WIDTH/8, remaining -= 1, beat_cnt -= 1.
  - out_last=1 when remaining transitions to 0.
  - Set error on any of: r_resp != 2'b00, r_id != AXI_ID, r_last mismatch with beat_cnt==1. Data is still forwarded.
  - Burst ends on the handshake with beat_cnt==1, regardless of r_last. Then go to ADDR if remaining != 0, else FINISH.
- Only one burst is outstanding at a time. A new AR is never issued before the previous burst's final beat.
- FINISH:
  - Wait until the output register is empty (out_valid==0, or out_valid && out_ready this cycle).
  - Then pulse done=1 for one cycle; busy=0 in the same cycle; return to IDLE.
- busy=1 in ADDR, DATA, and FINISH before the done pulse.
- start while busy: ignored.
- start in the done cycle: ignored (state is not IDLE yet).
- cur_addr wraps modulo 2^ADDR_WIDTH. The 4 KB rule prevents any single burst from crossing a page.
- Output stream: out_valid stays high with stable out_addr/out_data/out_last until out_ready.
- Throughput: one word per cycle when out_ready=1 and the memory streams back-to-back. Bubbles occur only at AR issue between bursts.

Test Plan:
1. base=0x100, count=4, MAX_BURST_LEN=16, out_ready=1, zero-wait slave -> single AR (addr 0x100, len 3). Stream addresses 0x100..0x10C with RAM contents; out_last on 4th word; done one cycle after last handshake; error=0.
2. base=0x0, count=40 -> three ARs: (0x0, len 15), (0x40, len 15), (0x80, len 7). 40 words in order; out_last only on addr 0x9C.
3. base=0xFF8, count=4 -> ARs (0xFF8, len 1) then (0x1000, len 1); no burst crosses 4 KB.
4. Random out_ready (50%) plus random ar_ready/r_valid stalls, count=37 -> all 37 words delivered exactly once, in order, matching memory image; r_ready never high while out_valid && !out_ready.
5. Slave returns SLVERR on beat 2 of count=4 -> all 4 words streamed; error=1 at done. A new start clears error.
6. count=0 -> no ar_valid; done pulses 2 cycles after start. rst asserted mid-DATA -> next cycle all outputs at reset values.
